// File: rtl/expr_seq_ctrl.sv
// Character-stream sequencer: checks digit/operator grammar and evaluates with '*' over '+'.
// Optional '-' operator is enabled by defining EXPR_SUB_EN.
module expr_seq_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             in_ready,
  output logic             out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic             err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    EXP_DIG,
    EXP_OP,
    ERR,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] prod;
  logic [LEN_W-1:0] len;
  logic             pend_mul;
  logic             neg;

  logic             xfer;
  logic             is_digit;
  logic             is_add;
  logic             is_mul;
  logic             is_sub;
  logic             is_eq;
  logic             full;
  logic [WIDTH-1:0] dval;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] acc;

  always_comb begin
    xfer     = in_valid & in_ready;
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_add   = (in == 8'h2B);
    is_mul   = (in == 8'h2A);
    is_eq    = (in == 8'h3D);
    // Digits occupy 0x30..0x39, so the low nibble is the digit value.
    dval     = WIDTH'(in[3:0]);
    full     = (32'(len) >= MAX_LEN);
    term     = neg ? (WIDTH'(0) - prod) : prod;
    acc      = sum + term;
  end

`ifdef EXPR_SUB_EN
  assign is_sub = (in == 8'h2D);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      neg <= 1'b0;
    end else if (state == IDLE || state == DONE) begin
      neg <= 1'b0;
    end else if (xfer && state == EXP_OP && !full && (is_add || is_sub)) begin
      neg <= is_sub;
    end
  end
`else
  assign is_sub = 1'b0;
  assign neg    = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      sum       <= '0;
      prod      <= '0;
      len       <= '0;
      pend_mul  <= 1'b0;
      in_ready  <= 1'b1;
      out       <= 1'b0;
      res_valid <= 1'b0;
      res       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (is_digit) begin
              prod     <= dval;
              sum      <= '0;
              pend_mul <= 1'b0;
              len      <= LEN_W'(1);
              out      <= 1'b1;
              state    <= EXP_OP;
            end else if (is_eq) begin
              res       <= '0;
              err       <= 1'b1;
              res_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= ERR;
            end
          end
        end

        EXP_DIG: begin
          if (xfer) begin
            if (is_digit && !full) begin
              prod  <= pend_mul ? (prod * dval) : dval;
              len   <= len + 1'b1;
              out   <= 1'b1;
              state <= EXP_OP;
            end else if (is_eq) begin
              res       <= '0;
              err       <= 1'b1;
              res_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else begin
              state <= ERR;
            end
          end
        end

        EXP_OP: begin
          if (xfer) begin
            out <= 1'b0;
            if (is_eq) begin
              res       <= acc;
              err       <= 1'b0;
              res_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DONE;
            end else if (is_mul && !full) begin
              pend_mul <= 1'b1;
              len      <= len + 1'b1;
              state    <= EXP_DIG;
            end else if ((is_add || is_sub) && !full) begin
              // Fold the finished product into the running sum; the new sign lives in neg.
              sum      <= acc;
              pend_mul <= 1'b0;
              len      <= len + 1'b1;
              state    <= EXP_DIG;
            end else begin
              state <= ERR;
            end
          end
        end

        ERR: begin
          if (xfer && is_eq) begin
            res       <= '0;
            err       <= 1'b1;
            res_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= DONE;
          end
        end

        DONE: begin
          if (res_ready) begin
            sum       <= '0;
            prod      <= '0;
            len       <= '0;
            pend_mul  <= 1'b0;
            res       <= '0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          out      <= 1'b0;
        end
      endcase
    end
  end

endmodule
